// File: rtl/pattern_scan_ctrl.sv
// Configurable serial pattern detector sequenced over a bounded scan window.
// Counts matches, records the first match position and pulses done at window end.
module pattern_scan_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 8,
  parameter int MCNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [MAXLEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_overlap,
  input  logic [CNT_W-1:0]  cfg_window,
  input  logic              start,
  input  logic              abort,
  input  logic              din,
  input  logic              din_valid,
  output logic              busy,
  output logic              done,
  output logic              flag,
  output logic [MCNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0]  first_pos,
  output logic              first_vld,
  output logic              cfg_err,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [MAXLEN-1:0] PAT_RST = MAXLEN'(8'h55);
  localparam logic [LEN_W-1:0]  LEN_MAX = LEN_W'(MAXLEN);

  state_t              state;
  logic [MAXLEN-1:0]   cfg_pattern_q, act_pattern;
  logic [LEN_W-1:0]    cfg_len_q, act_len;
  logic                cfg_overlap_q, act_overlap;
  logic [CNT_W-1:0]    cfg_window_q, act_window;
  logic [MAXLEN-1:0]   hist;
  logic [LEN_W-1:0]    fill;
  logic [CNT_W-1:0]    bit_idx;

  logic [MAXLEN-1:0]   hist_nxt, len_mask;
  logic [LEN_W-1:0]    fill_nxt;
  logic                hit, cfg_ok, last_bit;

  always_comb begin
    hist_nxt = {hist[MAXLEN-2:0], din};
    fill_nxt = (fill >= LEN_MAX) ? LEN_MAX : fill + 1'b1;
    len_mask = ~({MAXLEN{1'b1}} << act_len);
    hit      = (fill_nxt >= act_len) && ((hist_nxt & len_mask) == (act_pattern & len_mask));
    cfg_ok   = (cfg_len_q != '0) && (cfg_len_q <= LEN_MAX) && (cfg_window_q != '0);
    last_bit = (bit_idx == act_window - 1'b1);
  end

  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cfg_pattern_q <= PAT_RST;
      cfg_len_q     <= LEN_MAX;
      cfg_overlap_q <= 1'b1;
      cfg_window_q  <= '1;
      act_pattern   <= PAT_RST;
      act_len       <= LEN_MAX;
      act_overlap   <= 1'b1;
      act_window    <= '1;
      hist          <= '0;
      fill          <= '0;
      bit_idx       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      flag          <= 1'b0;
      match_cnt     <= '0;
      first_pos     <= '0;
      first_vld     <= 1'b0;
      cfg_err       <= 1'b0;
    end else begin
      flag <= 1'b0;
      done <= 1'b0;
      if (cfg_we && state == IDLE) begin
        cfg_pattern_q <= cfg_pattern;
        cfg_len_q     <= cfg_len;
        cfg_overlap_q <= cfg_overlap;
        cfg_window_q  <= cfg_window;
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (cfg_ok) begin
              // Snapshot the pre-edge config so a same-cycle write cannot alter this scan.
              act_pattern <= cfg_pattern_q;
              act_len     <= cfg_len_q;
              act_overlap <= cfg_overlap_q;
              act_window  <= cfg_window_q;
              hist        <= '0;
              fill        <= '0;
              bit_idx     <= '0;
              match_cnt   <= '0;
              first_pos   <= '0;
              first_vld   <= 1'b0;
              cfg_err     <= 1'b0;
              busy        <= 1'b1;
              state       <= SCAN;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (din_valid) begin
            hist    <= hist_nxt;
            bit_idx <= bit_idx + 1'b1;
            fill    <= (hit && !act_overlap) ? '0 : fill_nxt;
            if (hit) begin
              flag <= 1'b1;
              if (match_cnt != '1) match_cnt <= match_cnt + 1'b1;
              if (!first_vld) begin
                first_pos <= bit_idx;
                first_vld <= 1'b1;
              end
            end
            if (last_bit) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: hand-computed match positions are queued
// and checked against every flag pulse, plus counter, done and error checks.
module tb_pattern_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       cfg_overlap = 1'b0;
  logic [7:0] cfg_window = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       busy, done, flag, first_vld, cfg_err;
  logic [3:0] match_cnt;
  logic [7:0] first_pos;
  logic [1:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int bidx;
  int done_at;
  logic fd_same;
  logic [31:0] exp_q[$];

  pattern_scan_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
    .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_window(cfg_window),
    .start(start), .abort(abort), .din(din), .din_valid(din_valid),
    .busy(busy), .done(done), .flag(flag), .match_cnt(match_cnt),
    .first_pos(first_pos), .first_vld(first_vld), .cfg_err(cfg_err),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic write_cfg(input logic [7:0] pat, input logic [3:0] len,
                           input logic ov, input logic [7:0] win);
    cfg_we = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov; cfg_window = win;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bidx = 0; done_at = -1; fd_same = 1'b0;
  endtask

  task automatic run_stream(input logic [31:0] bits, input int n, input logic stall);
    for (int i = 0; i < n; i++) begin
      din = bits[n-1-i];
      din_valid = 1'b1;
      @(posedge clk); #1;
      if (flag) begin
        if (exp_q.size() == 0) chk("flag_extra", {31'b0, flag}, 32'd0);
        else chk("flag_pos", bidx, exp_q.pop_front());
      end
      if (done) done_at = bidx;
      if (flag && done) fd_same = 1'b1;
      bidx++;
      if (stall) begin
        din_valid = 1'b0;
        din = ~din;
        @(posedge clk); #1;
        chk("stall_quiet", {30'b0, flag, done}, 32'd0);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic finish_scan(input int cnt, input int pos, input int dat);
    chk("match_cnt", match_cnt, cnt);
    chk("first_pos", first_pos, pos);
    chk("first_vld", first_vld, 1);
    chk("done_at", done_at, dat);
    chk("missing_flags", exp_q.size(), 0);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("done_pulse_len", done, 0);
    chk("idle_after_done", state_dbg, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flag", flag, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_pos", first_pos, 0);
    chk("rst_fvld", first_vld, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_state", state_dbg, 0);

    // Default pattern, window 16
    write_cfg(8'h55, 4'd8, 1'b1, 8'd16);
    do_start();
    chk("t1_busy", busy, 1);
    exp_q.push_back(7); exp_q.push_back(9);
    run_stream(32'b0101010101, 10, 1'b0);
    chk("t1_mid_cnt", match_cnt, 2);
    chk("t1_mid_busy", busy, 1);
    run_stream(32'b000000, 6, 1'b0);
    finish_scan(2, 7, 15);

    // 101 non-overlapping, then overlapping
    write_cfg(8'h05, 4'd3, 1'b0, 8'd8);
    do_start();
    exp_q.push_back(2); exp_q.push_back(7);
    run_stream(32'b10101101, 8, 1'b0);
    chk("t2_flag_with_done", fd_same, 1);
    finish_scan(2, 2, 7);

    write_cfg(8'h05, 4'd3, 1'b1, 8'd8);
    do_start();
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(7);
    run_stream(32'b10101101, 8, 1'b0);
    finish_scan(3, 2, 7);

    // Write and start together: scan uses the old 101/3/8 config
    cfg_we = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b0; cfg_window = 8'd20;
    do_start();
    cfg_we = 1'b0;
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(7);
    run_stream(32'b10101101, 8, 1'b0);
    finish_scan(3, 2, 7);

    // Saturation with the config written above
    do_start();
    for (int i = 0; i < 20; i++) exp_q.push_back(i);
    run_stream(32'hFFFFF, 20, 1'b0);
    finish_scan(15, 0, 19);

    // Illegal configs
    for (int k = 0; k < 3; k++) begin
      case (k)
        0:       write_cfg(8'h05, 4'd0, 1'b1, 8'd5);
        1:       write_cfg(8'h05, 4'd9, 1'b1, 8'd5);
        default: write_cfg(8'h05, 4'd3, 1'b1, 8'd0);
      endcase
      do_start();
      chk("ill_state", state_dbg, 0);
      chk("ill_err", cfg_err, 1);
      chk("ill_busy", busy, 0);
    end
    write_cfg(8'h05, 4'd3, 1'b1, 8'd8);
    do_start();
    chk("legal_clr_err", cfg_err, 0);
    chk("legal_busy", busy, 1);

    // Same scan at half rate
    exp_q.push_back(2); exp_q.push_back(4); exp_q.push_back(7);
    run_stream(32'b10101101, 8, 1'b1);
    finish_scan(3, 2, 7);

    // Abort after bit 5; the aborted-cycle bit would have matched
    do_start();
    exp_q.push_back(2); exp_q.push_back(4);
    run_stream(32'b101010, 6, 1'b0);
    abort = 1'b1; din = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; din_valid = 1'b0;
    chk("abort_flag", flag, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cnt", match_cnt, 2);
    chk("abort_pos", first_pos, 2);
    chk("abort_state", state_dbg, 0);
    chk("abort_missing", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("abort_no_done", done, 0);

    // Mid-scan reset
    do_start();
    exp_q.push_back(2);
    run_stream(32'b101, 3, 1'b0);
    chk("pre_rst_cnt", match_cnt, 1);
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_flag", flag, 0);
    chk("mrst_cnt", match_cnt, 0);
    chk("mrst_pos", first_pos, 0);
    chk("mrst_fvld", first_vld, 0);
    chk("mrst_state", state_dbg, 0);

    // Default config restored: 01010101 / len 8
    do_start();
    exp_q.push_back(7);
    run_stream(32'b01010101, 8, 1'b0);
    chk("dflt_cnt", match_cnt, 1);
    chk("dflt_pos", first_pos, 7);
    chk("dflt_missing", exp_q.size(), 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("dflt_abort_state", state_dbg, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Controller that configures and sequences a programmable serial pattern detector over a bounded scan window. Software loads the pattern, its length, the overlap mode and the window size, then issues start. The block consumes qualified serial bits, pulses flag on each match, counts matches and records the first match position. It signals done when the window is exhausted. It sits between the register/config logic and the serial bit stream, replacing fixed hard-coded sequence detectors.

Parameters:
MAXLEN, 8, maximum pattern length in bits
LEN_W, 4, width of cfg_len; equals clog2(MAXLEN)+1
CNT_W, 8, width of window and bit-position counters
MCNT_W, 4, width of the match counter

Ports:
clk  input  1  rising-edge clock; the only clock
rst  input  1  synchronous, active-high reset
cfg_we  input  1  config write strobe; honoured only in IDLE
cfg_pattern  input  MAXLEN  pattern; bit [cfg_len-1] is the oldest bit and is compared first
cfg_len  input  LEN_W  pattern length; legal range 1..MAXLEN
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping
cfg_window  input  CNT_W  number of bits to scan; legal range 1..2^CNT_W-1
start  input  1  begin scan; honoured only in IDLE
abort  input  1  cancel scan; honoured only in SCAN
din  input  1  serial data bit
din_valid  input  1  din qualifier; one bit is consumed per clk with din_valid=1 in SCAN
busy  output  1  high in SCAN
done  output  1  one-cycle pulse when the window completes
flag  output  1  one-cycle pulse per match
match_cnt  output  MCNT_W  matches in the current or last scan; saturates at all-ones
first_pos  output  CNT_W  0-based bit index that completed the first match
first_vld  output  1  first_pos is valid
cfg_err  output  1  sticky; set by start with an illegal config

Behaviour:
- Reset: state=IDLE. busy, done, flag, first_vld and cfg_err are 0. match_cnt=0, first_pos=0.
- Config registers reset to pattern=8'b01010101, len=8, overlap=1, window=all-ones.
- Config: cfg_we in IDLE loads all four config registers at the edge. cfg_we outside IDLE is ignored.
- start with cfg_we in the same cycle: the write takes effect, but start uses the pre-edge config registers.
- FSM states IDLE, SCAN, DONE:
  - IDLE + start, with legal config: go to SCAN. Clear match_cnt, first_pos, first_vld, the bit index, the history and the fill count. Clear cfg_err.
  - IDLE + start, with illegal config (len=0, len>MAXLEN or window=0): stay in IDLE and set cfg_err=1.
  - SCAN + abort: go to IDLE. No done pulse. Counters keep their values. abort takes priority over a bit consumed in the same cycle; that bit is discarded.
  - SCAN + consumed bit: shift din into the history (MAXLEN bits, newest in bit 0). Increment the fill count, saturating at MAXLEN. Increment the bit index.
  - SCAN: when the consumed bit is bit index window-1, go to DONE.
  - DONE: lasts one cycle with done=1, then goes to IDLE. start during DONE is ignored.
- Match test: evaluated on each consumed bit, using the history including the new bit.
  - Match when fill >= len and history[len-1:0] == pattern[len-1:0].
  - Registered: flag=1 for exactly the cycle after the consuming edge.
  - A match on the last window bit gives flag and done in the same cycle.
- Overlap: overlap=1 keeps the history and fill after a match. overlap=0 resets the fill to 0 after a match.
- match_cnt increments per match and holds at 2^MCNT_W-1.
- On the first match: first_pos = that bit's index, first_vld=1. Both hold until the next start.
- din_valid=0 in SCAN: nothing changes and the scan stalls indefinitely. din is ignored outside SCAN.
- rst mid-scan: immediate return to full reset state. No done pulse.

Test Plan:
- Reset defaults with window=16, start, then stream 0101010101 (10 bits): flag pulses after bit indices 7 and 9; match_cnt=2; first_pos=7; done 1 cycle after bit 15.
- pattern=3'b101, len=3, overlap=0, window=8, stream 10101101: matches at indices 2 and 7 only; match_cnt=2. Same stream with overlap=1: matches at 2, 4 and 7; match_cnt=3.
- Saturation: pattern=1'b1, len=1, window=20, all-ones stream: match_cnt=15 at done; first_pos=0.
- Illegal config: cfg_len=0 then start: state stays IDLE; cfg_err=1; busy=0. A legal start afterwards clears cfg_err.
- Stalls and abort: din_valid toggled 1/0 every cycle gives an identical match result at half rate. abort asserted after bit 5: busy drops the next cycle, no done, match_cnt unchanged.
- Last-bit match and mid-scan reset: a match completing at index window-1 gives flag and done in the same cycle. rst asserted in SCAN returns all outputs to reset values the next cycle, and config returns to 01010101/8.
